vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 196 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator with fetch-ahead alignment pipeline and buffer swap handshake
// Define VGA_TEST_PATTERN_EN to add the test_en input and an eight-bar colour pattern.
module vga_timing_gen #(
   parameter int PIXEL_BITS = 4,
   parameter int CLK_DIV    = 2,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int FETCH_LAT  = 2,
   localparam int H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP,
   localparam int V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP,
   localparam int X_BITS    = $clog2(H_ACTIVE),
   localparam int Y_BITS    = $clog2(V_ACTIVE)
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                  test_en,
`endif
   output logic                  fetch_valid,
   output logic [X_BITS-1:0]     fetch_x,
   output logic [Y_BITS-1:0]     fetch_y,
   input  logic [PIXEL_BITS-1:0] pix_r,
   input  logic [PIXEL_BITS-1:0] pix_g,
   input  logic [PIXEL_BITS-1:0] pix_b,
   output logic [PIXEL_BITS-1:0] vga_r,
   output logic [PIXEL_BITS-1:0] vga_g,
   output logic [PIXEL_BITS-1:0] vga_b,
   output logic                  h_sync,
   output logic                  v_sync,
   output logic                  vga_active,
   output logic                  frame_start,
   input  logic                  swap_req,
   output logic                  swap_ack,
   output logic                  buf_sel
);
   localparam int HC_BITS = $clog2(H_TOTAL);
   localparam int VC_BITS = $clog2(V_TOTAL);
   localparam logic [HC_BITS-1:0] H_LAST      = HC_BITS'(H_TOTAL - 1);
   localparam logic [HC_BITS-1:0] H_SYNC_END  = HC_BITS'(H_SYNC);
   localparam logic [HC_BITS-1:0] H_ACT_START = HC_BITS'(H_SYNC + H_BP);
   localparam logic [HC_BITS-1:0] H_ACT_END   = HC_BITS'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [VC_BITS-1:0] V_LAST      = VC_BITS'(V_TOTAL - 1);
   localparam logic [VC_BITS-1:0] V_SYNC_END  = VC_BITS'(V_SYNC);
   localparam logic [VC_BITS-1:0] V_ACT_START = VC_BITS'(V_SYNC + V_BP);
   localparam logic [VC_BITS-1:0] V_ACT_END   = VC_BITS'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [VC_BITS-1:0] V_SWAP      = VC_BITS'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic HS_ACT  = 1'(HS_POL);
   localparam logic HS_IDLE = ~HS_ACT;
   localparam logic VS_ACT  = 1'(VS_POL);
   localparam logic VS_IDLE = ~VS_ACT;

   logic                  pix_en;
   logic [HC_BITS-1:0]    h_count;
   logic [VC_BITS-1:0]    v_count;
   logic                  h_act, v_act, hs0, vs0, act0;
   logic                  swap_pt;
   logic [FETCH_LAT-1:0]  pipe_hs, pipe_vs, pipe_act;
   logic [PIXEL_BITS-1:0] col_r, col_g, col_b;

   generate
      if (CLK_DIV == 1) begin : g_nodiv
         assign pix_en = 1'b1;
      end else begin : g_div
         localparam int DIV_W = $clog2(CLK_DIV);
         localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
         logic [DIV_W-1:0] div_cnt;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               div_cnt <= '0;
            else if (div_cnt == DIV_LAST)
               div_cnt <= '0;
            else
               div_cnt <= div_cnt + 1'b1;
         end
         assign pix_en = (div_cnt == DIV_LAST);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_count <= '0;
         v_count <= '0;
      end else if (pix_en) begin
         if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
         end else begin
            h_count <= h_count + 1'b1;
         end
      end
   end

   // Stage 0: region decode straight from the beam counters
   assign h_act       = (h_count >= H_ACT_START) && (h_count <= H_ACT_END);
   assign v_act       = (v_count >= V_ACT_START) && (v_count <= V_ACT_END);
   assign hs0         = (h_count < H_SYNC_END) ? HS_ACT : HS_IDLE;
   assign vs0         = (v_count < V_SYNC_END) ? VS_ACT : VS_IDLE;
   assign act0        = h_act && v_act;
   assign fetch_valid = act0;
   assign fetch_x     = act0 ? X_BITS'(h_count - H_ACT_START) : '0;
   assign fetch_y     = act0 ? Y_BITS'(v_count - V_ACT_START) : '0;
   assign swap_pt     = pix_en && (h_count == '0) && (v_count == V_SWAP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_hs  <= {FETCH_LAT{HS_IDLE}};
         pipe_vs  <= {FETCH_LAT{VS_IDLE}};
         pipe_act <= '0;
      end else if (pix_en) begin
         pipe_hs[0]  <= hs0;
         pipe_vs[0]  <= vs0;
         pipe_act[0] <= act0;
         for (int i = 1; i < FETCH_LAT; i++) begin
            pipe_hs[i]  <= pipe_hs[i-1];
            pipe_vs[i]  <= pipe_vs[i-1];
            pipe_act[i] <= pipe_act[i-1];
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   logic [X_BITS-1:0] pipe_x [FETCH_LAT];
   logic [X_BITS-1:0] bar_full;
   logic [2:0]        bar_k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FETCH_LAT; i++)
            pipe_x[i] <= '0;
      end else if (pix_en) begin
         pipe_x[0] <= fetch_x;
         for (int i = 1; i < FETCH_LAT; i++)
            pipe_x[i] <= pipe_x[i-1];
      end
   end

   assign bar_full = pipe_x[FETCH_LAT-1] / X_BITS'(BAR_W);
   assign bar_k    = bar_full[2:0];

   always_comb begin
      col_r = pix_r;
      col_g = pix_g;
      col_b = pix_b;
      if (test_en) begin
         col_r = {PIXEL_BITS{bar_k[2]}};
         col_g = {PIXEL_BITS{bar_k[1]}};
         col_b = {PIXEL_BITS{bar_k[0]}};
      end
   end
`else
   assign col_r = pix_r;
   assign col_g = pix_g;
   assign col_b = pix_b;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_sync     <= HS_IDLE;
         v_sync     <= VS_IDLE;
         vga_active <= 1'b0;
         vga_r      <= '0;
         vga_g      <= '0;
         vga_b      <= '0;
      end else if (pix_en) begin
         h_sync     <= pipe_hs[FETCH_LAT-1];
         v_sync     <= pipe_vs[FETCH_LAT-1];
         vga_active <= pipe_act[FETCH_LAT-1];
         vga_r      <= pipe_act[FETCH_LAT-1] ? col_r : '0;
         vga_g      <= pipe_act[FETCH_LAT-1] ? col_g : '0;
         vga_b      <= pipe_act[FETCH_LAT-1] ? col_b : '0;
      end
   end

   // Swaps are sampled only at the first front-porch line, so one frame grants at most one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_start <= 1'b0;
         swap_ack    <= 1'b0;
         buf_sel     <= 1'b0;
      end else begin
         frame_start <= pix_en && (h_count == '0) && (v_count == '0);
         swap_ack    <= swap_pt && swap_req;
         if (swap_pt && swap_req)
            buf_sel <= ~buf_sel;
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen on two reduced timing configurations
module tb_vga_timing_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rst_s;
   logic       fv, hs, vs, va, fs, sreq, sack, bsel;
   logic [3:0] fx, pr, pg, pb, vr, vg, vb;
   logic [2:0] fy;
   logic       fv_s, hs_s, vs_s, va_s, fs_s, sreq_s, sack_s, bsel_s;
   logic [1:0] fx_s;
   logic [0:0] fy_s;
   logic [3:0] pr_s, pg_s, pb_s, vr_s, vg_s, vb_s;

   logic [3:0] fb_r0, fb_r1, fb_g0, fb_g1, fbs_r0, fbs_r1, fbs_g0, fbs_g1;
   logic       exp_buf, exp_buf_s;
   int         errors = 0;
   int         checks = 0;
   int         hs_cnt, va_cnt;

   vga_timing_gen #(
      .PIXEL_BITS(4), .CLK_DIV(2),
      .H_SYNC(4), .H_BP(4), .H_ACTIVE(16), .H_FP(4),
      .V_SYNC(2), .V_BP(2), .V_ACTIVE(6), .V_FP(2),
      .HS_POL(0), .VS_POL(0), .FETCH_LAT(2)
   ) dut (
      .clk(clk), .rst(rst), .fetch_valid(fv), .fetch_x(fx), .fetch_y(fy),
      .pix_r(pr), .pix_g(pg), .pix_b(pb), .vga_r(vr), .vga_g(vg), .vga_b(vb),
      .h_sync(hs), .v_sync(vs), .vga_active(va), .frame_start(fs),
      .swap_req(sreq), .swap_ack(sack), .buf_sel(bsel)
   );

   vga_timing_gen #(
      .PIXEL_BITS(4), .CLK_DIV(1),
      .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
      .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1),
      .HS_POL(1), .VS_POL(1), .FETCH_LAT(2)
   ) dut_s (
      .clk(clk), .rst(rst_s), .fetch_valid(fv_s), .fetch_x(fx_s), .fetch_y(fy_s),
      .pix_r(pr_s), .pix_g(pg_s), .pix_b(pb_s), .vga_r(vr_s), .vga_g(vg_s), .vga_b(vb_s),
      .h_sync(hs_s), .v_sync(vs_s), .vga_active(va_s), .frame_start(fs_s),
      .swap_req(sreq_s), .swap_ack(sack_s), .buf_sel(bsel_s)
   );

   task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at j=%0d observed=%h expected=%h", tag, j, obs, exp);
      end
   endtask

   // Medium config: 28-pixel lines, 12-line frames, two clocks per pixel, outputs lag 3 ticks
   function automatic logic [14:0] m_pins(input int j);
      int k, h, v;
      logic a;
      if (j < 6) return {1'b1, 1'b1, 1'b0, 12'h000};
      k = (j - 6) / 2;
      h = k % 28;
      v = (k / 28) % 12;
      a = (h >= 8) && (h < 24) && (v >= 4) && (v < 10);
      return {(h >= 4), (v >= 2), a, a ? 4'(h - 8) : 4'h0, a ? 4'(v - 4) : 4'h0, a ? 4'hA : 4'h0};
   endfunction

   function automatic logic [7:0] m_fetch(input int j);
      int p, h, v;
      logic a;
      p = j / 2;
      h = p % 28;
      v = (p / 28) % 12;
      a = (h >= 8) && (h < 24) && (v >= 4) && (v < 10);
      return a ? {1'b1, 4'(h - 8), 3'(v - 4)} : 8'h00;
   endfunction

   // Small config: 10-pixel lines, 5-line frames, one clock per pixel, active-high syncs
   function automatic logic [14:0] s_pins(input int s);
      int k, h, v;
      logic a;
      if (s < 3) return 15'h0000;
      k = s - 3;
      h = k % 10;
      v = (k / 10) % 5;
      a = (h >= 4) && (h < 8) && (v >= 2) && (v < 4);
      return {(h < 2), (v < 1), a, a ? 4'(h - 4) : 4'h0, a ? 4'(v - 2) : 4'h0, a ? 4'h5 : 4'h0};
   endfunction

   function automatic logic [3:0] s_fetch(input int s);
      int h, v;
      logic a;
      h = s % 10;
      v = (s / 10) % 5;
      a = (h >= 4) && (h < 8) && (v >= 2) && (v < 4);
      return a ? {1'b1, 2'(h - 4), 1'(v - 2)} : 4'h0;
   endfunction

   task automatic step_m(input int j);
      logic ack_e, fs_e;
      int   k;
      ack_e = 1'b0;
      fs_e  = 1'b0;
      if (j >= 2 && j % 2 == 0) begin
         k     = (j - 2) / 2;
         fs_e  = (k % 336 == 0);
         ack_e = (k % 336 == 280) && sreq;
      end
      if (ack_e) exp_buf = ~exp_buf;
      chk("pins", j, 32'({hs, vs, va, vr, vg, vb}), 32'(m_pins(j)));
      chk("fetch", j, 32'({fv, fx, fy}), 32'(m_fetch(j)));
      chk("ctl", j, 32'({fs, sack, bsel}), 32'({fs_e, ack_e, exp_buf}));
      // Framebuffer stand-in: data returns two pixel ticks after the fetch
      if (j % 2 == 1) begin
         pr = fb_r1; fb_r1 = fb_r0; fb_r0 = fx;
         pg = fb_g1; fb_g1 = fb_g0; fb_g0 = {1'b0, fy};
      end
   endtask

   task automatic step_s(input int s);
      logic ack_e, fs_e;
      ack_e = 1'b0;
      fs_e  = 1'b0;
      if (s >= 1) begin
         fs_e  = ((s - 1) % 50 == 0);
         ack_e = ((s - 1) % 50 == 40) && sreq_s;
      end
      if (ack_e) exp_buf_s = ~exp_buf_s;
      chk("s_pins", s, 32'({hs_s, vs_s, va_s, vr_s, vg_s, vb_s}), 32'(s_pins(s)));
      chk("s_fetch", s, 32'({fv_s, fx_s, fy_s}), 32'(s_fetch(s)));
      chk("s_ctl", s, 32'({fs_s, sack_s, bsel_s}), 32'({fs_e, ack_e, exp_buf_s}));
      pr_s = fbs_r1; fbs_r1 = fbs_r0; fbs_r0 = {2'b00, fx_s};
      pg_s = fbs_g1; fbs_g1 = fbs_g0; fbs_g0 = {3'b000, fy_s};
   endtask

   initial begin
      rst = 1'b1; rst_s = 1'b1; sreq = 1'b0; sreq_s = 1'b0;
      pr = '0; pg = '0; pb = 4'hA; pr_s = '0; pg_s = '0; pb_s = 4'h5;
      fb_r0 = '0; fb_r1 = '0; fb_g0 = '0; fb_g1 = '0;
      fbs_r0 = '0; fbs_r1 = '0; fbs_g0 = '0; fbs_g1 = '0;
      exp_buf = 1'b0; exp_buf_s = 1'b0; hs_cnt = 0; va_cnt = 0;
      repeat (3) @(negedge clk);
      chk("rst_pins", 0, 32'({hs, vs, va, vr, vg, vb}), 32'({1'b1, 1'b1, 1'b0, 12'h000}));
      chk("rst_fetch", 0, 32'({fv, fx, fy}), 32'h0);
      chk("rst_ctl", 0, 32'({fs, sack, bsel}), 32'h0);
      chk("rst_s_pins", 0, 32'({hs_s, vs_s, va_s, vr_s, vg_s, vb_s}), 32'h0);

      // Frame 0: request rises in the swap-point clock; frame 1: mid-frame request;
      // frame 2: request withdrawn early; frames 3..5: request held throughout
      rst = 1'b0;
      for (int j = 0; j <= 4454; j++) begin
         if (j > 0) @(negedge clk);
         step_m(j);
         if (j == 561 || j == 872 || j == 1544 || j == 2116) sreq = 1'b1;
         if (j == 562 || j == 1234 || j == 1844 || j == 3922) sreq = 1'b0;
      end
      chk("pre_rst_active", 4454, 32'({va, vr}), 32'({1'b1, 4'd4}));
      chk("pre_rst_buf", 4454, 32'(bsel), 32'd1);

      rst = 1'b1;
      #1;
      chk("mid_rst_pins", 4454, 32'({hs, vs, va, vr, vg, vb}), 32'({1'b1, 1'b1, 1'b0, 12'h000}));
      chk("mid_rst_fetch", 4454, 32'({fv, fx, fy}), 32'h0);
      chk("mid_rst_ctl", 4454, 32'({fs, sack, bsel}), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_buf = 1'b0;
      for (int j = 0; j <= 700; j++) begin
         if (j > 0) @(negedge clk);
         step_m(j);
         if (j == 5)   chk("first_upd_pre", j, 32'({hs, vs}), 32'b11);
         if (j == 6)   chk("first_upd_sync", j, 32'({hs, vs}), 32'b00);
         if (j == 239) chk("fetch_before", j, 32'(fv), 32'd0);
         if (j == 240) chk("fetch_first", j, 32'({fv, fx, fy}), 32'({1'b1, 4'd0, 3'd0}));
         if (j == 270) chk("fetch_x_last", j, 32'({fv, fx}), 32'({1'b1, 4'd15}));
         if (j == 272) chk("fetch_fall", j, 32'(fv), 32'd0);
         if (j == 244) chk("ramp_pre", j, 32'({va, vr}), 32'd0);
         if (j == 246) chk("ramp_0", j, 32'({va, vr}), 32'({1'b1, 4'd0}));
         if (j == 248) chk("ramp_1", j, 32'({va, vr}), 32'({1'b1, 4'd1}));
         if (j == 674) chk("frame_start_2", j, 32'(fs), 32'd1);
      end

      sreq_s = 1'b1;
      rst_s  = 1'b0;
      for (int s = 0; s <= 130; s++) begin
         if (s > 0) @(negedge clk);
         step_s(s);
         if (s >= 3 && s < 53) begin
            if (hs_s) hs_cnt++;
            if (va_s) va_cnt++;
         end
      end
      chk("s_hsync_clks", 53, 32'(hs_cnt), 32'd10);
      chk("s_active_clks", 53, 32'(va_cnt), 32'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
